vga_capture: RTL
================

Name: vga_capture

Overview:
- Receive-side counterpart of the VGA output path: watches the VGA pins driven by video_driver, recovers pixel coordinates and colour, and checks the sync timing.
- Produces per-frame statistics (pixel sum, line count, error flags) plus a single-pixel colour probe, so benches and on-board self-test can check animator output.
- Runs on CLOCK_50 alongside video_driver; samples pins on VGA_CLK rising edges detected in the clk domain.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
H_TOTAL, 800, pixel clocks per line (HS falling edge to HS falling edge)

Ports:
clk  in  1  system clock (CLOCK_50)
reset_n  in  1  asynchronous active-low reset
vga_clk  in  1  VGA_CLK pin (clk/2)
vga_hs  in  1  VGA_HS, active low
vga_vs  in  1  VGA_VS, active low
vga_blank_n  in  1  VGA_BLANK_N, 1 = active video
vga_r, vga_g, vga_b  in  8 each  colour pins
probe_x  in  10  probe column
probe_y  in  9  probe row
pix_valid  out  1  one-clk strobe, sampled active pixel
pix_x  out  10  column of sampled pixel
pix_y  out  9  row of sampled pixel
pix_rgb  out  24  {r,g,b} of sampled pixel
probe_rgb  out  24  colour last seen at (probe_x, probe_y)
locked  out  1  frame alignment acquired
frame_done  out  1  one-clk pulse, end of full frame
frame_sum  out  24  sum of {r,g,b} over the last frame, mod 2^24
line_count  out  10  active lines in the last frame
err_hlen, err_vlen, err_htotal  out  1 each  sticky timing errors

Behaviour:
- Pixel strobe: vga_clk registered into vclk_q. pstb = vga_clk & ~vclk_q. All pin sampling and counting happens only on pstb cycles, using the pin values present in that cycle.
- Reset (reset_n low, async): every output and internal register is 0, and the FSM enters UNLOCKED.
- Edge detection: previous values of hs, vs and blank_n are kept, updated on pstb only.
- FSM:
  - UNLOCKED -> ALIGNED on a VS falling edge.
  - ALIGNED -> LOCKED at the next VS falling edge.
  - In ALIGNED, capture outputs run, but frame_done is suppressed (partial frame).
  - locked = 1 only in LOCKED. No transition leaves LOCKED except reset.
- Pixel counting:
  - On pstb with blank_n = 1: pix_valid = 1 on the next clk, with pix_x = hcnt, pix_y = vcnt, pix_rgb = pins.
  - hcnt increments, saturating at 1023. hcnt clears at each blank_n rising edge.
  - On a blank_n falling edge: if hcnt != H_ACTIVE, set err_hlen. vcnt then increments, saturating at 511.
- Frame boundary (VS falling edge):
  - In LOCKED, on the following clk: frame_done = 1, frame_sum <= acc, line_count <= vcnt. If vcnt != V_ACTIVE, set err_vlen.
  - In every state, acc and vcnt clear at this point.
  - frame_sum and line_count hold until the next frame_done.
  - A VS falling edge on the same pstb as a blank_n falling edge: the line end is processed first, then the frame end.
- Accumulator: acc <= acc + {r,g,b} mod 2^24 for each active pixel.
- HS period check:
  - hper counts pstb cycles between HS falling edges, saturating at 1023.
  - In LOCKED, set err_htotal if hper != H_TOTAL at an HS falling edge.
  - The first HS edge after reset only starts the count.
- Probe: when an active pixel has hcnt == probe_x and vcnt == probe_y, probe_rgb <= pins. It holds otherwise, including across frames.
- Error flags are sticky until reset_n. Errors never clear locked.
- Latency: pin sample to pix_* = 1 clk. VS edge to frame_done = 1 clk.

Test Plan:
- Constant colour: two full 640x480 frames at 0x010203 -> first frame_done only at the end of frame 2 (ALIGNED then LOCKED); frame_sum = 0x6E1000, line_count = 480, all errors 0.
- Rectangle: black frame with a red 0xFF0000 rectangle at x 20..29, y 100..109; probe = (25,105) -> probe_rgb = 0xFF0000. Probe (30,105) -> 0x000000. frame_sum = 100*0xFF0000 mod 2^24 = 0x9C0000.
- Short line: line 7 has only 639 active pixels -> err_hlen = 1 after that line. frame_done still pulses. line_count = 480. locked stays 1.
- Bad HS period: one line with H_TOTAL 799 while LOCKED -> err_htotal = 1, other flags 0. The same glitch while ALIGNED -> err_htotal stays 0.
- Missing lines: frame with 479 active lines -> line_count = 479, err_vlen = 1.
- Mid-frame reset: reset_n low at line 200 -> all outputs 0 immediately. After release, no frame_done until two VS falling edges have passed. A pix_valid at (0,0) appears only after the first VS falling edge.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: recovers pixels, per-frame statistics and a colour probe
// from the VGA pins, and checks line, frame and HS-period timing.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic [9:0]  probe_x,
  input  logic [8:0]  probe_y,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic [23:0] probe_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [23:0] frame_sum,
  output logic [9:0]  line_count,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic        err_htotal
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGNED  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [8:0] VA = 9'(V_ACTIVE);
  localparam logic [9:0] HT = 10'(H_TOTAL);

  state_e state_q, state_d;
  logic   cap, lock;

  logic        vclk_q, hs_q, vs_q, bl_q, hs_seen_q;
  logic [9:0]  hcnt_q, hcnt_d, hper_q, hper_d;
  logic [8:0]  vcnt_q, vcnt_d;
  logic [23:0] acc_q, acc_d;
  logic        pv_q, pv_d, done_q, done_d;
  logic [9:0]  px_q, px_d, lcnt_q, lcnt_d;
  logic [8:0]  py_q, py_d;
  logic [23:0] prgb_q, prgb_d, probe_q, probe_d;
  logic [23:0] fsum_q, fsum_d;
  logic        eh_q, eh_d, ev_q, ev_d, et_q, et_d;

  logic        pstb, act, hs_fall, vs_fall;
  logic        bl_rise, bl_fall;
  logic [23:0] rgb, acc_l;
  logic [9:0]  hx;
  logic [8:0]  vl;

  assign pstb    = vga_clk & ~vclk_q;
  assign act     = pstb & vga_blank_n;
  assign hs_fall = pstb & hs_q & ~vga_hs;
  assign vs_fall = pstb & vs_q & ~vga_vs;
  assign bl_rise = pstb & ~bl_q & vga_blank_n;
  assign bl_fall = pstb & bl_q & ~vga_blank_n;
  assign rgb     = {vga_r, vga_g, vga_b};

  // Line end is folded in before a coincident frame end.
  assign hx    = bl_rise ? 10'd0 : hcnt_q;
  assign vl    = (bl_fall && vcnt_q != 9'h1ff) ? vcnt_q + 9'd1 : vcnt_q;
  assign acc_l = act ? acc_q + rgb : acc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= UNLOCKED;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UNLOCKED: if (vs_fall) state_d = ALIGNED;
      ALIGNED:  if (vs_fall) state_d = LOCKED;
      LOCKED:   state_d = LOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  always_comb begin
    cap  = (state_q != UNLOCKED);
    lock = (state_q == LOCKED);
  end

  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vs_fall ? 9'd0 : vl;
    acc_d   = vs_fall ? 24'd0 : acc_l;
    hper_d  = hper_q;
    pv_d    = act & cap;
    px_d    = px_q;
    py_d    = py_q;
    prgb_d  = prgb_q;
    probe_d = probe_q;
    done_d  = vs_fall & lock;
    fsum_d  = fsum_q;
    lcnt_d  = lcnt_q;
    eh_d    = eh_q | (bl_fall & cap & (hcnt_q != HA));
    ev_d    = ev_q;
    et_d    = et_q | (hs_fall & lock & hs_seen_q & (hper_q != HT));
    if (act) hcnt_d = (hx == 10'h3ff) ? hx : hx + 10'd1;
    if (hs_fall)
      hper_d = 10'd1;
    else if (pstb && hper_q != 10'h3ff)
      hper_d = hper_q + 10'd1;
    if (pv_d) begin
      px_d   = hx;
      py_d   = vcnt_q;
      prgb_d = rgb;
      if (hx == probe_x && vcnt_q == probe_y) probe_d = rgb;
    end
    if (done_d) begin
      fsum_d = acc_l;
      lcnt_d = {1'b0, vl};
      if (vl != VA) ev_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vclk_q    <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      bl_q      <= 1'b0;
      hs_seen_q <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hper_q    <= '0;
      acc_q     <= '0;
      pv_q      <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      prgb_q    <= '0;
      probe_q   <= '0;
      done_q    <= 1'b0;
      fsum_q    <= '0;
      lcnt_q    <= '0;
      eh_q      <= 1'b0;
      ev_q      <= 1'b0;
      et_q      <= 1'b0;
    end else begin
      vclk_q <= vga_clk;
      if (pstb) begin
        hs_q <= vga_hs;
        vs_q <= vga_vs;
        bl_q <= vga_blank_n;
      end
      hs_seen_q <= hs_seen_q | hs_fall;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hper_q    <= hper_d;
      acc_q     <= acc_d;
      pv_q      <= pv_d;
      px_q      <= px_d;
      py_q      <= py_d;
      prgb_q    <= prgb_d;
      probe_q   <= probe_d;
      done_q    <= done_d;
      fsum_q    <= fsum_d;
      lcnt_q    <= lcnt_d;
      eh_q      <= eh_d;
      ev_q      <= ev_d;
      et_q      <= et_d;
    end
  end

  assign pix_valid  = pv_q;
  assign pix_x      = px_q;
  assign pix_y      = py_q;
  assign pix_rgb    = prgb_q;
  assign probe_rgb  = probe_q;
  assign locked     = lock;
  assign frame_done = done_q;
  assign frame_sum  = fsum_q;
  assign line_count = lcnt_q;
  assign err_hlen   = eh_q;
  assign err_vlen   = ev_q;
  assign err_htotal = et_q;

endmodule
